bubble_warmup_ctrl: RTL and testbench

//  Bubble-memory warm-up sequencer. Sits downstream of the temperature sensor and alongside the elapsed-seconds

---
 rtl/bubble_warmup_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_bubble_warmup_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/bubble_warmup_ctrl.sv
// Bubble-memory warm-up sequencer: heats to target, restarts the seconds counter,
// waits for a timed stable settle window, then raises READY (or FAULT on timeout/overtemp).
module bubble_warmup_ctrl #(
    parameter logic [11:0] TEMP_TARGET    = 12'd1200,
    parameter logic [11:0] TEMP_HYST      = 12'd16,
    parameter logic [15:0] SETTLE_SEC     = 16'd30,
    parameter logic [15:0] TIMEOUT_SEC    = 16'd600,
    parameter logic [7:0]  STABLE_SAMPLES = 8'd8
) (
    input  logic        MCLK,
    input  logic        RESET,
    input  logic        ENABLE,
    input  logic        TEMP_VALID,
    input  logic [11:0] TEMP_DATA,
    input  logic [15:0] TIMEELAPSED,
    input  logic        OVFL,
    output logic        TIMER_nRESET,
    output logic        TIMER_nSTART,
    output logic        HEATER_ON,
    output logic        READY,
    output logic        FAULT,
    output logic [1:0]  FAULT_CODE,
    output logic [2:0]  STATE
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_TRST   = 3'd1,
        S_TSTART = 3'd2,
        S_HEAT   = 3'd3,
        S_SETTLE = 3'd4,
        S_READY  = 3'd5,
        S_FAULT  = 3'd6
    } state_e;

    typedef enum logic {
        PH_HEAT   = 1'b0,
        PH_SETTLE = 1'b1
    } phase_e;

    localparam logic [1:0] CODE_NONE     = 2'd0;
    localparam logic [1:0] CODE_TIMEOUT  = 2'd1;
    localparam logic [1:0] CODE_OVERTEMP = 2'd2;

    // Thresholds in 14 bits; clamp checks are arranged so nothing wraps.
    localparam logic [13:0] TMAX = 14'd4095;
    localparam logic [13:0] TGT  = {2'b00, TEMP_TARGET};
    localparam logic [13:0] HY1  = {2'b00, TEMP_HYST};
    localparam logic [13:0] HY4  = {TEMP_HYST, 2'b00};
    localparam logic [13:0] LO1  = (HY1 > TGT) ? 14'd0 : TGT - HY1;
    localparam logic [13:0] HI1  = (HY1 > TMAX - TGT) ? TMAX : TGT + HY1;
    localparam logic [13:0] LO4  = (HY4 > TGT) ? 14'd0 : TGT - HY4;
    localparam logic [13:0] HI4  = (HY4 > TMAX - TGT) ? TMAX : TGT + HY4;

    state_e      state_q, state_d;
    phase_e      phase_q, phase_d;
    logic        heater_q, heater_d;
    logic        ready_q, ready_d;
    logic        fault_q, fault_d;
    logic [1:0]  code_q, code_d;
    logic [7:0]  stable_q, stable_d;
    logic        first_q, first_d;
    logic        nreset_q, nreset_d;
    logic        nstart_q, nstart_d;

    logic [13:0] sample;
    logic        overtemp;
    logic        timer_expired;
    logic        in_window;
    logic        thermo_active;

    always_comb begin
        sample        = {2'b00, TEMP_DATA};
        overtemp      = TEMP_VALID && (sample > HI4);
        in_window     = (sample >= LO1) && (sample <= HI1);
        // The counter has not cleared yet on the first cycle after TSTART.
        timer_expired = !first_q && ((TIMEELAPSED >= TIMEOUT_SEC) || OVFL);
        thermo_active = TEMP_VALID && ((state_q == S_SETTLE) || (state_q == S_READY));

        state_d  = state_q;
        phase_d  = phase_q;
        heater_d = heater_q;
        code_d   = code_q;
        stable_d = stable_q;
        first_d  = (state_q == S_TSTART);

        if (thermo_active) begin
            if (sample < LO1)
                heater_d = 1'b1;
            else if (sample >= TGT)
                heater_d = 1'b0;
            if (!in_window)
                stable_d = 8'd0;
            else if (stable_q != 8'hFF)
                stable_d = stable_q + 8'd1;
        end

        case (state_q)
            S_IDLE: begin
                stable_d = 8'd0;
                if (ENABLE) begin
                    state_d = S_TRST;
                    phase_d = PH_HEAT;
                end
            end
            S_TRST:   state_d = S_TSTART;
            S_TSTART: begin
                stable_d = 8'd0;
                state_d  = (phase_q == PH_SETTLE) ? S_SETTLE : S_HEAT;
            end
            S_HEAT: begin
                if (overtemp) begin
                    state_d = S_FAULT;
                    code_d  = CODE_OVERTEMP;
                end else if (timer_expired) begin
                    state_d = S_FAULT;
                    code_d  = CODE_TIMEOUT;
                end else if (TEMP_VALID && (sample >= TGT)) begin
                    state_d = S_TRST;
                    phase_d = PH_SETTLE;
                end
            end
            S_SETTLE: begin
                if (overtemp) begin
                    state_d = S_FAULT;
                    code_d  = CODE_OVERTEMP;
                end else if (timer_expired) begin
                    state_d = S_FAULT;
                    code_d  = CODE_TIMEOUT;
                end else if (!first_q && (TIMEELAPSED >= SETTLE_SEC) &&
                             (stable_q >= STABLE_SAMPLES)) begin
                    state_d = S_READY;
                end
            end
            S_READY: begin
                if (overtemp) begin
                    state_d = S_FAULT;
                    code_d  = CODE_OVERTEMP;
                end else if (TEMP_VALID && (sample < LO4)) begin
                    state_d = S_TRST;
                    phase_d = PH_HEAT;
                end
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase

        if (!ENABLE)
            state_d = S_IDLE;

        if (state_d == S_IDLE) begin
            code_d   = CODE_NONE;
            phase_d  = PH_HEAT;
            stable_d = 8'd0;
        end

        // Registered outputs are derived from the next state so they line up with STATE.
        case (state_d)
            S_HEAT:           heater_d = 1'b1;
            S_IDLE, S_FAULT:  heater_d = 1'b0;
            default:          ;
        endcase
        nreset_d = !((state_d == S_IDLE) || (state_d == S_TRST));
        nstart_d = (state_d != S_TSTART);
        ready_d  = (state_d == S_READY);
        fault_d  = (state_d == S_FAULT);
    end

    always_ff @(posedge MCLK) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            phase_q  <= PH_HEAT;
            heater_q <= 1'b0;
            ready_q  <= 1'b0;
            fault_q  <= 1'b0;
            code_q   <= CODE_NONE;
            stable_q <= 8'd0;
            first_q  <= 1'b0;
            nreset_q <= 1'b0;
            nstart_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            heater_q <= heater_d;
            ready_q  <= ready_d;
            fault_q  <= fault_d;
            code_q   <= code_d;
            stable_q <= stable_d;
            first_q  <= first_d;
            nreset_q <= nreset_d;
            nstart_q <= nstart_d;
        end
    end

    assign TIMER_nRESET = nreset_q;
    assign TIMER_nSTART = nstart_q;
    assign HEATER_ON    = heater_q;
    assign READY        = ready_q;
    assign FAULT        = fault_q;
    assign FAULT_CODE   = code_q;
    assign STATE        = state_q;

endmodule

// File: tb/tb_bubble_warmup_ctrl.sv
// Directed bench for bubble_warmup_ctrl: each task drives one scenario and checks
// the packed output vector {STATE,HEATER_ON,READY,FAULT,FAULT_CODE,nRESET,nSTART}.
module tb_bubble_warmup_ctrl;

    logic        MCLK = 1'b0;
    logic        RESET;
    logic        ENABLE;
    logic        TEMP_VALID;
    logic [11:0] TEMP_DATA;
    logic [15:0] TIMEELAPSED;
    logic        OVFL;
    logic        TIMER_nRESET;
    logic        TIMER_nSTART;
    logic        HEATER_ON;
    logic        READY;
    logic        FAULT;
    logic [1:0]  FAULT_CODE;
    logic [2:0]  STATE;

    int n_chk  = 0;
    int n_pass = 0;
    logic [9:0] exp_v;

    bubble_warmup_ctrl dut (
        .MCLK(MCLK), .RESET(RESET), .ENABLE(ENABLE),
        .TEMP_VALID(TEMP_VALID), .TEMP_DATA(TEMP_DATA),
        .TIMEELAPSED(TIMEELAPSED), .OVFL(OVFL),
        .TIMER_nRESET(TIMER_nRESET), .TIMER_nSTART(TIMER_nSTART),
        .HEATER_ON(HEATER_ON), .READY(READY), .FAULT(FAULT),
        .FAULT_CODE(FAULT_CODE), .STATE(STATE)
    );

    always #5 MCLK = ~MCLK;

    wire [9:0] obs = {STATE, HEATER_ON, READY, FAULT, FAULT_CODE, TIMER_nRESET, TIMER_nSTART};

    function automatic logic [9:0] pk(input logic [2:0] s, input logic h, input logic r,
                                      input logic f, input logic [1:0] c,
                                      input logic nr, input logic ns);
        return {s, h, r, f, c, nr, ns};
    endfunction

    task automatic tick();
        @(posedge MCLK);
        #1;
    endtask

    task automatic sample(input logic [11:0] d);
        TEMP_VALID = 1'b1;
        TEMP_DATA  = d;
        tick();
        TEMP_VALID = 1'b0;
    endtask

    task automatic go_heat();
        ENABLE = 1'b1;
        repeat (3) tick();
    endtask

    task automatic heat_to_settle();
        sample(12'd1200);
        repeat (2) tick();
    endtask

    task automatic test_reset();
        RESET = 1'b1; ENABLE = 1'b0;
        repeat (3) tick();
        exp_v = pk(3'd0, 0, 0, 0, 2'd0, 0, 1);
        n_chk++; if (obs !== exp_v) $display("FAIL reset_idle got %b want %b", obs, exp_v); else n_pass++;
        RESET = 1'b0; ENABLE = 1'b1;
        tick();
        exp_v = pk(3'd1, 0, 0, 0, 2'd0, 0, 1);
        n_chk++; if (obs !== exp_v) $display("FAIL start_trst got %b want %b", obs, exp_v); else n_pass++;
        tick();
        exp_v = pk(3'd2, 0, 0, 0, 2'd0, 1, 0);
        n_chk++; if (obs !== exp_v) $display("FAIL start_tstart got %b want %b", obs, exp_v); else n_pass++;
        tick();
        exp_v = pk(3'd3, 1, 0, 0, 2'd0, 1, 1);
        n_chk++; if (obs !== exp_v) $display("FAIL start_heat got %b want %b", obs, exp_v); else n_pass++;
    endtask

    task automatic test_nominal();
        TIMEELAPSED = 16'd0;
        sample(12'd1000);
        exp_v = pk(3'd3, 1, 0, 0, 2'd0, 1, 1);
        n_chk++; if (obs !== exp_v) $display("FAIL nom_heat_below got %b want %b", obs, exp_v); else n_pass++;
        sample(12'd1200);
        exp_v = pk(3'd1, 1, 0, 0, 2'd0, 0, 1);
        n_chk++; if (obs !== exp_v) $display("FAIL nom_trst got %b want %b", obs, exp_v); else n_pass++;
        tick();
        exp_v = pk(3'd2, 1, 0, 0, 2'd0, 1, 0);
        n_chk++; if (obs !== exp_v) $display("FAIL nom_tstart got %b want %b", obs, exp_v); else n_pass++;
        tick();
        exp_v = pk(3'd4, 1, 0, 0, 2'd0, 1, 1);
        n_chk++; if (obs !== exp_v) $display("FAIL nom_settle got %b want %b", obs, exp_v); else n_pass++;
        TIMEELAPSED = 16'd30;
        repeat (8) sample(12'd1195);
        exp_v = pk(3'd4, 1, 0, 0, 2'd0, 1, 1);
        n_chk++; if (obs !== exp_v) $display("FAIL nom_pre_ready got %b want %b", obs, exp_v); else n_pass++;
        tick();
        exp_v = pk(3'd5, 1, 1, 0, 2'd0, 1, 1);
        n_chk++; if (obs !== exp_v) $display("FAIL nom_ready got %b want %b", obs, exp_v); else n_pass++;
    endtask

    task automatic test_ready_drop();
        sample(12'd1130);
        exp_v = pk(3'd1, 1, 0, 0, 2'd0, 0, 1);
        n_chk++; if (obs !== exp_v) $display("FAIL drop_trst got %b want %b", obs, exp_v); else n_pass++;
        tick();
        exp_v = pk(3'd2, 1, 0, 0, 2'd0, 1, 0);
        n_chk++; if (obs !== exp_v) $display("FAIL drop_tstart got %b want %b", obs, exp_v); else n_pass++;
        tick();
        exp_v = pk(3'd3, 1, 0, 0, 2'd0, 1, 1);
        n_chk++; if (obs !== exp_v) $display("FAIL drop_heat got %b want %b", obs, exp_v); else n_pass++;
    endtask

    task automatic test_heat_timeout();
        // Already in the first HEAT cycle: the stale TIMEELAPSED must be ignored once.
        TIMEELAPSED = 16'd600; TEMP_VALID = 1'b1; TEMP_DATA = 12'd900;
        tick();
        exp_v = pk(3'd3, 1, 0, 0, 2'd0, 1, 1);
        n_chk++; if (obs !== exp_v) $display("FAIL to_first_cycle got %b want %b", obs, exp_v); else n_pass++;
        tick();
        TEMP_VALID = 1'b0;
        exp_v = pk(3'd6, 0, 0, 1, 2'd1, 1, 1);
        n_chk++; if (obs !== exp_v) $display("FAIL to_fault got %b want %b", obs, exp_v); else n_pass++;
        TIMEELAPSED = 16'd0;
        tick();
        n_chk++; if (obs !== exp_v) $display("FAIL to_sticky got %b want %b", obs, exp_v); else n_pass++;
        ENABLE = 1'b0;
        tick();
        exp_v = pk(3'd0, 0, 0, 0, 2'd0, 0, 1);
        n_chk++; if (obs !== exp_v) $display("FAIL abort_fault got %b want %b", obs, exp_v); else n_pass++;
        go_heat();
        OVFL = 1'b1;
        tick();
        exp_v = pk(3'd3, 1, 0, 0, 2'd0, 1, 1);
        n_chk++; if (obs !== exp_v) $display("FAIL ovfl_first_cycle got %b want %b", obs, exp_v); else n_pass++;
        tick();
        exp_v = pk(3'd6, 0, 0, 1, 2'd1, 1, 1);
        n_chk++; if (obs !== exp_v) $display("FAIL ovfl_fault got %b want %b", obs, exp_v); else n_pass++;
        OVFL = 1'b0; ENABLE = 1'b0;
        tick();
    endtask

    task automatic test_overtemp();
        go_heat();
        heat_to_settle();
        tick();
        TIMEELAPSED = 16'd600;
        sample(12'd1265);
        exp_v = pk(3'd6, 0, 0, 1, 2'd2, 1, 1);
        n_chk++; if (obs !== exp_v) $display("FAIL ot_over_timeout got %b want %b", obs, exp_v); else n_pass++;
        TIMEELAPSED = 16'd0; ENABLE = 1'b0;
        tick();
        exp_v = pk(3'd0, 0, 0, 0, 2'd0, 0, 1);
        n_chk++; if (obs !== exp_v) $display("FAIL ot_clear got %b want %b", obs, exp_v); else n_pass++;
    endtask

    task automatic test_stability();
        go_heat();
        heat_to_settle();
        TIMEELAPSED = 16'd0;
        repeat (7) sample(12'd1195);
        sample(12'd1230);
        TIMEELAPSED = 16'd30;
        tick();
        exp_v = pk(3'd4, 0, 0, 0, 2'd0, 1, 1);
        n_chk++; if (obs !== exp_v) $display("FAIL stab_break got %b want %b", obs, exp_v); else n_pass++;
        sample(12'd1190);
        n_chk++; if (obs !== exp_v) $display("FAIL thermo_hold got %b want %b", obs, exp_v); else n_pass++;
        sample(12'd1183);
        exp_v = pk(3'd4, 1, 0, 0, 2'd0, 1, 1);
        n_chk++; if (obs !== exp_v) $display("FAIL thermo_on got %b want %b", obs, exp_v); else n_pass++;
        repeat (8) sample(12'd1195);
        tick();
        exp_v = pk(3'd5, 1, 1, 0, 2'd0, 1, 1);
        n_chk++; if (obs !== exp_v) $display("FAIL stab_ready got %b want %b", obs, exp_v); else n_pass++;
    endtask

    task automatic test_abort();
        ENABLE = 1'b0;
        tick();
        exp_v = pk(3'd0, 0, 0, 0, 2'd0, 0, 1);
        n_chk++; if (obs !== exp_v) $display("FAIL abort_ready got %b want %b", obs, exp_v); else n_pass++;
        TIMEELAPSED = 16'd0;
        go_heat();
        ENABLE = 1'b0;
        tick();
        n_chk++; if (obs !== exp_v) $display("FAIL abort_heat got %b want %b", obs, exp_v); else n_pass++;
        go_heat();
        heat_to_settle();
        ENABLE = 1'b0; TEMP_VALID = 1'b1; TEMP_DATA = 12'd1265;
        tick();
        TEMP_VALID = 1'b0;
        n_chk++; if (obs !== exp_v) $display("FAIL abort_settle_prio got %b want %b", obs, exp_v); else n_pass++;
        go_heat();
        RESET = 1'b1;
        tick();
        RESET = 1'b0; ENABLE = 1'b0;
        n_chk++; if (obs !== exp_v) $display("FAIL reset_mid got %b want %b", obs, exp_v); else n_pass++;
    endtask

    initial begin
        RESET = 1'b1; ENABLE = 1'b0; TEMP_VALID = 1'b0; TEMP_DATA = 12'd0;
        TIMEELAPSED = 16'd0; OVFL = 1'b0;
        test_reset();
        test_nominal();
        test_ready_drop();
        test_heat_timeout();
        test_overtemp();
        test_stability();
        test_abort();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
